// File: rtl/layer_fx_controller_if.sv
// Event and layer-control signals between the game logic, the effect sequencer and the compositor.
interface layer_fx_controller_if;
  logic       startOfFrame;
  logic       holeHitReq;
  logic       wrongHoleReq;
  logic       gameOverReq;
  logic       restartReq;
  logic [7:0] layerEnable;
  logic       overrideEn;
  logic [7:0] overrideRGB;
  logic       busy;
  logic [1:0] fxState;

  modport master (
    output startOfFrame, holeHitReq, wrongHoleReq, gameOverReq, restartReq,
    input  layerEnable, overrideEn, overrideRGB, busy, fxState
  );

  modport slave (
    input  startOfFrame, holeHitReq, wrongHoleReq, gameOverReq, restartReq,
    output layerEnable, overrideEn, overrideRGB, busy, fxState
  );
endinterface

// File: rtl/layer_fx_controller.sv
// Frame-synchronous effect sequencer: turns game events into layer enables and a board colour override.
module layer_fx_controller #(
  parameter int unsigned FLASH_FRAMES = 8,
  parameter int unsigned BLINK_PERIOD = 16,
  parameter logic [7:0]  OK_COLOR     = 8'h1C,
  parameter logic [7:0]  BAD_COLOR    = 8'hE0
) (
  input  logic                  clk,
  input  logic                  reset,
  layer_fx_controller_if.slave  fx
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    FLASH_OK  = 2'd1,
    FLASH_BAD = 2'd2,
    GAME_OVER = 2'd3
  } fx_state_t;

  localparam logic [7:0] FLASH_LAST = 8'(FLASH_FRAMES - 1);
  localparam logic [7:0] BLINK_LAST = 8'(BLINK_PERIOD - 1);

  fx_state_t  state, state_n;
  logic [7:0] frame_cnt, frame_n;
  logic [7:0] blink_cnt, blink_n;
  logic       stat_vis, vis_n;
  logic       pend_ok, pend_bad, pend_over, pend_rst;
  logic       p_ok, p_bad, p_over, p_rst;
  logic       pok_n, pbad_n, pover_n, prst_n;
  logic       in_go;
  logic [7:0] le_n, rgb_n;
  logic       ov_n;

  // Requests arriving this cycle are merged in before the decision so a
  // request coincident with startOfFrame is served in that same frame.
  always_comb begin
    in_go   = (state == GAME_OVER);
    p_ok    = pend_ok   | (fx.holeHitReq   & ~in_go);
    p_bad   = pend_bad  | (fx.wrongHoleReq & ~in_go);
    p_over  = pend_over | (fx.gameOverReq  & ~in_go);
    p_rst   = pend_rst  | fx.restartReq;

    state_n = state;
    frame_n = frame_cnt;
    blink_n = blink_cnt;
    vis_n   = stat_vis;
    pok_n   = p_ok;
    pbad_n  = p_bad;
    pover_n = p_over;
    prst_n  = p_rst;

    if (fx.startOfFrame) begin
      if (p_rst) begin
        state_n = IDLE;
        frame_n = '0;
        blink_n = '0;
        vis_n   = 1'b1;
        pok_n   = 1'b0;
        pbad_n  = 1'b0;
        pover_n = 1'b0;
        prst_n  = 1'b0;
      end else if (p_over && !in_go) begin
        state_n = GAME_OVER;
        blink_n = '0;
        vis_n   = 1'b1;
        pover_n = 1'b0;
      end else if (in_go) begin
        if (blink_cnt == BLINK_LAST) begin
          blink_n = '0;
          vis_n   = ~stat_vis;
        end else begin
          blink_n = blink_cnt + 8'd1;
        end
      end else if (state == IDLE || frame_cnt == '0) begin
        // Idle, or the last frame of a flash: start the next waiting flash.
        state_n = IDLE;
        if (p_bad) begin
          state_n = FLASH_BAD;
          frame_n = FLASH_LAST;
          pbad_n  = 1'b0;
        end else if (p_ok) begin
          state_n = FLASH_OK;
          frame_n = FLASH_LAST;
          pok_n   = 1'b0;
        end
      end else begin
        frame_n = frame_cnt - 8'd1;
      end
    end
  end

  always_comb begin
    le_n  = '1;
    ov_n  = 1'b0;
    rgb_n = '0;
    unique case (state_n)
      IDLE: ;
      FLASH_OK: begin
        ov_n  = 1'b1;
        rgb_n = OK_COLOR;
      end
      FLASH_BAD: begin
        ov_n     = 1'b1;
        rgb_n    = BAD_COLOR;
        le_n[3]  = frame_n[0];
      end
      GAME_OVER: le_n = {vis_n, 3'b000, 4'hF};
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      frame_cnt      <= '0;
      blink_cnt      <= '0;
      stat_vis       <= 1'b1;
      pend_ok        <= 1'b0;
      pend_bad       <= 1'b0;
      pend_over      <= 1'b0;
      pend_rst       <= 1'b0;
      fx.layerEnable <= '1;
      fx.overrideEn  <= 1'b0;
      fx.overrideRGB <= '0;
      fx.busy        <= 1'b0;
    end else begin
      state          <= state_n;
      frame_cnt      <= frame_n;
      blink_cnt      <= blink_n;
      stat_vis       <= vis_n;
      pend_ok        <= pok_n;
      pend_bad       <= pbad_n;
      pend_over      <= pover_n;
      pend_rst       <= prst_n;
      fx.layerEnable <= le_n;
      fx.overrideEn  <= ov_n;
      fx.overrideRGB <= rgb_n;
      fx.busy        <= (state_n != IDLE);
    end
  end

  assign fx.fxState = state;

endmodule

// File: tb/tb_layer_fx_controller.sv
// Directed, table-driven bench for layer_fx_controller with default parameters.
module tb_layer_fx_controller;

  logic clk = 1'b0;
  logic reset;
  layer_fx_controller_if bus ();

  layer_fx_controller #(
    .FLASH_FRAMES(8),
    .BLINK_PERIOD(16),
    .OK_COLOR(8'h1C),
    .BAD_COLOR(8'hE0)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .fx   (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       sof, hole, wrong, over, rst;
    logic [1:0] st;
    logic [7:0] le;
    logic       ov;
    logic [7:0] rgb;
    logic       busy;
  } vec_t;

  vec_t tbl[$];
  int unsigned total = 0;
  int unsigned bad = 0;

  function automatic void add(input logic sof, hole, wrong, over, rst,
                              input logic [1:0] st, input logic [7:0] le,
                              input logic ov, input logic [7:0] rgb, input logic busy);
    vec_t v;
    v = '{sof:sof, hole:hole, wrong:wrong, over:over, rst:rst,
          st:st, le:le, ov:ov, rgb:rgb, busy:busy};
    tbl.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string name, input logic [1:0] st, input logic [7:0] le,
                         input logic ov, input logic [7:0] rgb, input logic busy);
    chk({name, ".fxState"},     32'(bus.fxState),     32'(st));
    chk({name, ".layerEnable"}, 32'(bus.layerEnable), 32'(le));
    chk({name, ".overrideEn"},  32'(bus.overrideEn),  32'(ov));
    chk({name, ".overrideRGB"}, 32'(bus.overrideRGB), 32'(rgb));
    chk({name, ".busy"},        32'(bus.busy),        32'(busy));
  endtask

  task automatic drive(input logic sof, hole, wrong, over, rst);
    bus.startOfFrame = sof;
    bus.holeHitReq   = hole;
    bus.wrongHoleReq = wrong;
    bus.gameOverReq  = over;
    bus.restartReq   = rst;
    @(posedge clk);
    #1;
    bus.startOfFrame = 1'b0;
    bus.holeHitReq   = 1'b0;
    bus.wrongHoleReq = 1'b0;
    bus.gameOverReq  = 1'b0;
    bus.restartReq   = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    bus.startOfFrame = 1'b0;
    bus.holeHitReq   = 1'b0;
    bus.wrongHoleReq = 1'b0;
    bus.gameOverReq  = 1'b0;
    bus.restartReq   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_all("reset", 2'd0, 8'hFF, 1'b0, 8'h00, 1'b0);
    reset = 1'b0;

    // A: correct-hole flash lasts 8 frames, back to idle on the 9th pulse
    add(0,1,0,0,0, 2'd0, 8'hFF, 0, 8'h00, 0);
    for (int i = 0; i < 8; i++) add(1,0,0,0,0, 2'd1, 8'hFF, 1, 8'h1C, 1);
    add(1,0,0,0,0, 2'd0, 8'hFF, 0, 8'h00, 0);

    // B: bad and ok together: bad first with blinking hole number, then ok
    add(1,1,1,0,0, 2'd2, 8'hFF, 1, 8'hE0, 1);
    for (int i = 1; i < 8; i++)
      add(1,0,0,0,0, 2'd2, (i % 2 == 1) ? 8'hF7 : 8'hFF, 1, 8'hE0, 1);
    for (int i = 0; i < 8; i++) add(1,0,0,0,0, 2'd1, 8'hFF, 1, 8'h1C, 1);
    add(1,0,0,0,0, 2'd0, 8'hFF, 0, 8'h00, 0);

    // C: game over preempts frame 3 of an ok flash, stat blinks 16/16
    add(1,1,0,0,0, 2'd1, 8'hFF, 1, 8'h1C, 1);
    add(1,0,0,0,0, 2'd1, 8'hFF, 1, 8'h1C, 1);
    add(1,0,0,0,0, 2'd1, 8'hFF, 1, 8'h1C, 1);
    add(0,0,0,1,0, 2'd1, 8'hFF, 1, 8'h1C, 1);
    add(1,0,0,0,0, 2'd3, 8'h8F, 0, 8'h00, 1);
    add(0,1,1,0,0, 2'd3, 8'h8F, 0, 8'h00, 1);
    for (int i = 0; i < 15; i++) add(1,0,0,0,0, 2'd3, 8'h8F, 0, 8'h00, 1);
    add(1,0,0,0,0, 2'd3, 8'h0F, 0, 8'h00, 1);
    for (int i = 0; i < 15; i++) add(1,0,0,0,0, 2'd3, 8'h0F, 0, 8'h00, 1);
    add(1,0,0,0,0, 2'd3, 8'h8F, 0, 8'h00, 1);
    add(1,0,0,0,1, 2'd0, 8'hFF, 0, 8'h00, 0);
    add(1,0,0,0,0, 2'd0, 8'hFF, 0, 8'h00, 0);
    add(1,0,0,0,0, 2'd0, 8'hFF, 0, 8'h00, 0);

    // D: restart wins over game over in the same frame
    add(0,0,0,1,1, 2'd0, 8'hFF, 0, 8'h00, 0);
    add(1,0,0,0,0, 2'd0, 8'hFF, 0, 8'h00, 0);
    add(1,0,0,0,0, 2'd0, 8'hFF, 0, 8'h00, 0);

    foreach (tbl[i]) begin
      drive(tbl[i].sof, tbl[i].hole, tbl[i].wrong, tbl[i].over, tbl[i].rst);
      chk_all($sformatf("vec%0d", i), tbl[i].st, tbl[i].le, tbl[i].ov, tbl[i].rgb, tbl[i].busy);
    end

    // No frame pulse for 1000 cycles: request waits, nothing changes
    drive(0,1,0,0,0);
    for (int c = 0; c < 1000; c++) begin
      @(posedge clk);
      #1;
      if (c % 100 == 99) chk_all($sformatf("nosof%0d", c), 2'd0, 8'hFF, 0, 8'h00, 0);
    end
    drive(1,0,0,0,0);
    chk_all("late_start", 2'd1, 8'hFF, 1, 8'h1C, 1);
    drive(1,0,0,0,1);
    chk_all("late_restart", 2'd0, 8'hFF, 0, 8'h00, 0);

    // Asynchronous reset in the middle of a bad flash with requests pending
    drive(1,0,1,0,0);
    drive(1,0,0,0,0);
    chk_all("pre_reset", 2'd2, 8'hF7, 1, 8'hE0, 1);
    drive(0,1,0,1,0);
    #3 reset = 1'b1;
    #1;
    chk_all("async_reset", 2'd0, 8'hFF, 0, 8'h00, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1,0,0,0,0);
      chk_all($sformatf("post_reset%0d", i), 2'd0, 8'hFF, 0, 8'h00, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/layer_fx_controller.md
Name: layer_fx_controller

Overview:
- Frame-synchronous sequencer that configures the screen compositor's eight layer inputs: per-layer enable mask, plus a board-layer colour override.
- Turns game events (correct hole, wrong hole, game over, restart) into timed visual effects (board flash, hole-number blink, stat blink, play-field hide).
- Sits between game-logic events and the layer priority mux. Each layer's draw request is ANDed with its enable bit. The board pixel colour is replaced when the override is active.

Parameters:
FLASH_FRAMES, 8, frames a hole-hit/wrong-hole flash lasts (2..255, even)
BLINK_PERIOD, 16, frames per half-period of the game-over stat blink (1..255)
OK_COLOR, 8'h1C, RGB332 board override colour for correct hole
BAD_COLOR, 8'hE0, RGB332 board override colour for wrong hole

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
startOfFrame  in  1  one-cycle pulse at start of vertical blank
holeHitReq  in  1  one-cycle pulse, ball sunk in correct hole
wrongHoleReq  in  1  one-cycle pulse, ball sunk in wrong hole
gameOverReq  in  1  one-cycle pulse, game ended
restartReq  in  1  one-cycle pulse, new game
layerEnable  out  8  [7]stat [6]line [5]whiteBall [4]redBall [3]holeNumber [2]holes [1]borders [0]board
overrideEn  out  1  board layer drawn with overrideRGB
overrideRGB  out  8  override colour
busy  out  1  effect in progress (fxState != IDLE)
fxState  out  2  IDLE=0, FLASH_OK=1, FLASH_BAD=2, GAME_OVER=3

Behaviour:
- Reset (async, any time, mid-effect included): fxState=IDLE, layerEnable=8'hFF, overrideEn=0, overrideRGB=8'h00, busy=0, pending flags cleared, counters cleared.
- All outputs are registered. State and outputs change only on a clk edge where startOfFrame=1, so they take new values the cycle after the pulse. There is no mid-frame tearing.
- Request capture: each request sets a sticky pending flag (pendOk, pendBad, pendOver, pendRestart).
  - Repeated requests of the same type collapse into one.
  - A request in the same cycle as startOfFrame is eligible for that frame's decision.
  - A served flag is cleared in the same cycle its state is entered.
  - In GAME_OVER, holeHitReq, wrongHoleReq and gameOverReq are ignored (not latched).
- Decision at each startOfFrame, in priority order:
  - pendRestart → IDLE, all pending cleared, from any state.
  - Else pendOver → GAME_OVER, from IDLE or either flash (preempts a flash).
  - Else, in IDLE: pendBad → FLASH_BAD, else pendOk → FLASH_OK.
  - A flash is never preempted by another flash. The waiting flash runs when the current one ends.
- FLASH_OK / FLASH_BAD:
  - On entry, frameCnt = FLASH_FRAMES-1.
  - Each subsequent startOfFrame decrements frameCnt.
  - At a startOfFrame with frameCnt=0: go to the next pending effect (same priority order), else IDLE. The effect therefore lasts exactly FLASH_FRAMES frames.
  - overrideEn=1 and layerEnable=8'hFF, except in FLASH_BAD where layerEnable[3]=frameCnt[0]. The hole number is visible on the first frame and alternates each frame.
  - overrideRGB=OK_COLOR or BAD_COLOR.
- GAME_OVER:
  - overrideEn=0, overrideRGB=8'h00.
  - layerEnable[6:4]=0 (line and balls hidden), [3:0]=1, [7]=statVisible.
  - On entry, statVisible=1 and blinkCnt=0. Each startOfFrame increments blinkCnt. When blinkCnt reaches BLINK_PERIOD-1 it wraps to 0 and statVisible toggles. The stat layer is visible for BLINK_PERIOD frames, then hidden for BLINK_PERIOD frames, repeating.
  - Remains until restart.
- IDLE: layerEnable=8'hFF, overrideEn=0, overrideRGB=8'h00.
- Counters are 8 bits wide and saturate-free within the parameter ranges. Parameter values outside those ranges are illegal.

Test Plan:
- Reset mid-FLASH_BAD → outputs return to reset values asynchronously. No effect resumes after reset release despite earlier pending requests.
- holeHitReq then startOfFrame → next cycle fxState=1, overrideEn=1, overrideRGB=8'h1C. Stays 8 frames; at the 9th startOfFrame returns to IDLE with layerEnable=8'hFF.
- wrongHoleReq and holeHitReq in the same cycle as startOfFrame → FLASH_BAD for 8 frames (layerEnable[3] pattern 1,0,1,0,...), then FLASH_OK for 8 frames, then IDLE.
- gameOverReq during frame 3 of FLASH_OK → at next startOfFrame fxState=3, layerEnable=8'h8F. After 16 frames 8'h0F, after 16 more 8'h8F. Hole requests in GAME_OVER cause no later flash.
- restartReq and gameOverReq in the same frame while IDLE → at startOfFrame fxState=0, busy=0, no GAME_OVER entered.
- No startOfFrame for 1000 cycles after holeHitReq → outputs unchanged. Effect starts only on the first pulse.
